// File: rtl/bcp_engine.sv
// bcp_engine: boolean-constraint-propagation datapath fed with clause indices by the solver control FSM.
// Define BCP_STATS_EN to add wrapping 16-bit clause/implication/conflict statistics outputs.
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif
`ifndef MAX_CLAUSES_BITS
`define MAX_CLAUSES_BITS 8
`endif

module bcp_engine #(
  parameter int LITS       = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int VB         = `MAX_VARS_BITS,
  parameter int CB         = `MAX_CLAUSES_BITS
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   reset_bcp,
  input  logic                   bcp_en,
  input  logic [CB-1:0]          bcp_clause_idx,
  output logic                   bcp_busy,
  output logic                   conflict,
  output logic                   bcp_overflow,
  output logic                   cdb_read,
  output logic [CB-1:0]          cdb_addr,
  input  logic [LITS*(VB+2)-1:0] cdb_lits,
  output logic                   vs_read,
  output logic [VB-1:0]          vs_var,
  input  logic                   vs_val,
  input  logic                   vs_unassign,
  output logic                   push_imply,
  output logic [VB-1:0]          var_in_imply,
  output logic                   val_in_imply,
  output logic                   type_in_imply,
  input  logic                   full_imply
`ifdef BCP_STATS_EN
  ,
  output logic [15:0]            stat_clauses,
  output logic [15:0]            stat_implies,
  output logic [15:0]            stat_conflicts
`endif
);

  localparam int LW = VB + 2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int KW = (LITS > 1) ? $clog2(LITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CL_WAIT,
    S_LIT_REQ,
    S_LIT_WAIT,
    S_RESOLVE,
    S_IMPLY
  } state_t;

  state_t state_q, state_d;

  // Request FIFO; pointers carry an extra wrap bit to tell full from empty.
  logic [CB-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full, fifo_push, fifo_pop, fifo_flush;

  logic [LITS*LW-1:0] lits_q;
  logic [KW-1:0]      k_q;
  logic [1:0]         ucnt_q;
  logic [VB-1:0]      unit_var_q;
  logic               unit_neg_q;

  logic [LW-1:0] slot;
  logic          slot_valid, slot_neg, last_slot, lit_true;
  logic [VB-1:0] slot_var;
  logic          conflict_set, clause_done;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign slot       = lits_q[int'(k_q)*LW +: LW];
  assign slot_valid = slot[LW-1];
  assign slot_neg   = slot[LW-2];
  assign slot_var   = slot[VB-1:0];
  assign last_slot  = (k_q == KW'(LITS-1));
  assign lit_true   = !vs_unassign && (vs_val ^ slot_neg);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    fifo_pop     = 1'b0;
    cdb_read     = 1'b0;
    vs_read      = 1'b0;
    push_imply   = 1'b0;
    conflict_set = 1'b0;
    clause_done  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty && !conflict) begin
          fifo_pop = 1'b1;
          cdb_read = 1'b1;
          state_d  = S_CL_WAIT;
        end
      end
      S_CL_WAIT: state_d = S_LIT_REQ;
      S_LIT_REQ: begin
        if (slot_valid) begin
          vs_read = 1'b1;
          state_d = S_LIT_WAIT;
        end else if (last_slot) begin
          state_d = S_RESOLVE;
        end
      end
      S_LIT_WAIT: begin
        if (lit_true) begin
          clause_done = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d = last_slot ? S_RESOLVE : S_LIT_REQ;
        end
      end
      S_RESOLVE: begin
        clause_done = 1'b1;
        if (ucnt_q == 2'd0) begin
          conflict_set = 1'b1;
          state_d      = S_IDLE;
        end else if (ucnt_q == 2'd1) begin
          state_d = S_IMPLY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_IMPLY: begin
        if (!full_imply) begin
          push_imply = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A flush request beats anything the FSM was about to do, including a pending push.
    if (reset_bcp) begin
      state_d      = S_IDLE;
      fifo_pop     = 1'b0;
      cdb_read     = 1'b0;
      vs_read      = 1'b0;
      push_imply   = 1'b0;
      conflict_set = 1'b0;
      clause_done  = 1'b0;
    end
  end

  assign fifo_push  = bcp_en && !conflict && !reset_bcp && (!fifo_full || fifo_pop);
  assign fifo_flush = reset_bcp || conflict_set;

  assign cdb_addr      = cdb_read ? fifo_mem[rd_ptr[AW-1:0]] : '0;
  assign vs_var        = vs_read ? slot_var : '0;
  assign var_in_imply  = unit_var_q;
  assign val_in_imply  = ~unit_neg_q;
  assign type_in_imply = 1'b1;
  assign bcp_busy      = !fifo_empty || (state_q != S_IDLE) || bcp_en;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (fifo_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are meaningful.
  always_ff @(posedge clock) begin
    if (fifo_push) fifo_mem[wr_ptr[AW-1:0]] <= bcp_clause_idx;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      conflict     <= 1'b0;
      bcp_overflow <= 1'b0;
    end else begin
      if (reset_bcp)         conflict <= 1'b0;
      else if (conflict_set) conflict <= 1'b1;
      if (bcp_en && !conflict && !reset_bcp && fifo_full && !fifo_pop) bcp_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lits_q     <= '0;
      k_q        <= '0;
      ucnt_q     <= '0;
      unit_var_q <= '0;
      unit_neg_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_CL_WAIT: begin
          lits_q <= cdb_lits;
          k_q    <= '0;
          ucnt_q <= '0;
        end
        S_LIT_REQ: if (!slot_valid && !last_slot) k_q <= k_q + KW'(1);
        S_LIT_WAIT: begin
          if (vs_unassign) begin
            if (ucnt_q == 2'd0) begin
              unit_var_q <= slot_var;
              unit_neg_q <= slot_neg;
            end
            if (ucnt_q != 2'd2) ucnt_q <= ucnt_q + 2'd1;
          end
          if (!lit_true && !last_slot) k_q <= k_q + KW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef BCP_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_clauses   <= '0;
      stat_implies   <= '0;
      stat_conflicts <= '0;
    end else begin
      if (clause_done)  stat_clauses   <= stat_clauses + 16'd1;
      if (push_imply)   stat_implies   <= stat_implies + 16'd1;
      if (conflict_set) stat_conflicts <= stat_conflicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bcp_engine.sv
// tb_bcp_engine: table-driven clause vectors plus directed backpressure, burst and async-reset sequences.
`timescale 1ns/1ps
module tb_bcp_engine;

  localparam int LITS = 3;
  localparam int VB   = 8;
  localparam int CB   = 8;
  localparam int LW   = VB + 2;

  logic                 clock = 1'b0;
  logic                 reset_n, reset_bcp, bcp_en, full_imply;
  logic [CB-1:0]        bcp_clause_idx;
  logic                 bcp_busy, conflict, bcp_overflow, cdb_read, vs_read;
  logic [CB-1:0]        cdb_addr;
  logic [LITS*LW-1:0]   cdb_lits = '0;
  logic [VB-1:0]        vs_var, var_in_imply;
  logic                 vs_val = 1'b0;
  logic                 vs_unassign = 1'b0;
  logic                 push_imply, val_in_imply, type_in_imply;
`ifdef BCP_STATS_EN
  logic [15:0]          stat_clauses, stat_implies, stat_conflicts;
`endif

  int n_checks = 0;
  int n_errors = 0;

  bcp_engine #(.LITS(LITS), .FIFO_DEPTH(4), .VB(VB), .CB(CB)) dut (
    .clock(clock), .reset_n(reset_n), .reset_bcp(reset_bcp),
    .bcp_en(bcp_en), .bcp_clause_idx(bcp_clause_idx),
    .bcp_busy(bcp_busy), .conflict(conflict), .bcp_overflow(bcp_overflow),
    .cdb_read(cdb_read), .cdb_addr(cdb_addr), .cdb_lits(cdb_lits),
    .vs_read(vs_read), .vs_var(vs_var), .vs_val(vs_val), .vs_unassign(vs_unassign),
    .push_imply(push_imply), .var_in_imply(var_in_imply), .val_in_imply(val_in_imply),
    .type_in_imply(type_in_imply), .full_imply(full_imply)
`ifdef BCP_STATS_EN
    , .stat_clauses(stat_clauses), .stat_implies(stat_implies), .stat_conflicts(stat_conflicts)
`endif
  );

  always #5 clock = ~clock;

  // Clause DB and var state table with one-cycle read latency.
  logic [LITS*LW-1:0] clause_mem  [2**CB];
  logic               var_val_mem [2**VB];
  logic               var_una_mem [2**VB];

  always @(posedge clock) begin
    if (cdb_read) cdb_lits <= clause_mem[cdb_addr];
    if (vs_read) begin
      vs_val      <= var_val_mem[vs_var];
      vs_unassign <= var_una_mem[vs_var];
    end
  end

  typedef struct {
    string              name;
    logic [LITS*LW-1:0] lits;
    logic [LITS-1:0]    una;
    logic [LITS-1:0]    val;
    int                 exp_cycles;   // -1: not checked
    int                 exp_pushes;
    int                 exp_var;
    logic               exp_val;
    logic               exp_conf;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [LW-1:0] lit(input logic v, input logic n, input int x);
    return {v, n, x[VB-1:0]};
  endfunction

  function automatic vec_t mk(input string name, input logic [LW-1:0] s2, input logic [LW-1:0] s1,
                              input logic [LW-1:0] s0, input logic [2:0] una, input logic [2:0] val,
                              input int cyc, input int pushes, input int pv, input logic pval,
                              input logic conf);
    vec_t r;
    r.name = name; r.lits = {s2, s1, s0}; r.una = una; r.val = val;
    r.exp_cycles = cyc; r.exp_pushes = pushes; r.exp_var = pv; r.exp_val = pval; r.exp_conf = conf;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_clause(input int idx, input vec_t v);
    logic [LW-1:0] s;
    clause_mem[idx] = v.lits;
    for (int k = 0; k < LITS; k++) begin
      s = v.lits[k*LW +: LW];
      if (s[LW-1]) begin
        var_una_mem[s[VB-1:0]] = v.una[k];
        var_val_mem[s[VB-1:0]] = v.val[k];
      end
    end
  endtask

  // Issues one request and counts busy cycles (request cycle included) until the engine idles.
  task automatic run_clause(input logic [CB-1:0] idx, output int cycles, output int pushes,
                            output logic [VB-1:0] pv, output logic pval, output logic ptype);
    cycles = 0; pushes = 0; pv = '0; pval = 1'b0; ptype = 1'b0;
    @(negedge clock); bcp_clause_idx = idx; bcp_en = 1'b1; #1;
    while (bcp_busy && cycles < 60) begin
      cycles++;
      if (push_imply) begin
        pushes++; pv = var_in_imply; pval = val_in_imply; ptype = type_in_imply;
      end
      @(negedge clock); bcp_en = 1'b0; #1;
    end
  endtask

  int            cyc, pushes, reads, first_push, idle_reads;
  logic [VB-1:0] pv;
  logic          pval, ptype, busy_gap;
  logic [CB-1:0] exp_addr [$];

  initial begin
    for (int i = 0; i < 2**VB; i++) begin var_val_mem[i] = 1'b0; var_una_mem[i] = 1'b1; end
    for (int i = 0; i < 2**CB; i++) clause_mem[i] = '0;

    vecs[0] = mk("sat_first", lit(1,0,3), lit(1,1,2), lit(1,0,1), 3'b000, 3'b001, 5,  0, 0, 0, 0);
    vecs[1] = mk("unit_x3",   lit(1,1,3), lit(1,0,2), lit(1,0,1), 3'b100, 3'b000, 11, 1, 3, 0, 0);
    vecs[2] = mk("unit_x5",   lit(0,0,0), lit(1,0,5), lit(1,1,4), 3'b010, 3'b001, -1, 1, 5, 1, 0);
    vecs[3] = mk("two_unas",  lit(1,0,8), lit(1,0,7), lit(1,0,6), 3'b111, 3'b000, 10, 0, 0, 0, 0);
    vecs[4] = mk("sat_mid",   lit(0,0,0), lit(1,1,2), lit(0,0,0), 3'b000, 3'b000, -1, 0, 0, 0, 0);
    vecs[5] = mk("unit_x9",   lit(1,0,1), lit(1,0,9), lit(0,0,0), 3'b010, 3'b000, -1, 1, 9, 1, 0);
    vecs[6] = mk("conf_2lit", lit(0,0,0), lit(1,0,2), lit(1,0,1), 3'b000, 3'b000, -1, 0, 0, 0, 1);
    vecs[7] = mk("conf_empty",lit(0,0,0), lit(0,0,0), lit(0,0,0), 3'b000, 3'b000, -1, 0, 0, 0, 1);
    vecs[8] = mk("unit_negx5",lit(1,1,7), lit(1,0,6), lit(1,1,5), 3'b001, 3'b100, 11, 1, 5, 0, 0);
    vecs[9] = mk("sat_last",  lit(1,0,3), lit(1,0,2), lit(1,0,1), 3'b011, 3'b100, 9,  0, 0, 0, 0);

    reset_n = 1'b0; reset_bcp = 1'b0; bcp_en = 1'b0; full_imply = 1'b0; bcp_clause_idx = '0;
    #1;
    check("rst_busy", bcp_busy, 0);
    check("rst_cdb_read", cdb_read, 0);
    check("rst_cdb_addr", cdb_addr, 0);
    check("rst_vs_read", vs_read, 0);
    check("rst_vs_var", vs_var, 0);
    check("rst_push", push_imply, 0);
    check("rst_conflict", conflict, 0);
    check("rst_overflow", bcp_overflow, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      load_clause(10 + i, vecs[i]);
      run_clause(CB'(10 + i), cyc, pushes, pv, pval, ptype);
      check({vecs[i].name, "_done"}, bcp_busy, 0);
      if (vecs[i].exp_cycles >= 0) check({vecs[i].name, "_cycles"}, cyc, vecs[i].exp_cycles);
      check({vecs[i].name, "_pushes"}, pushes, vecs[i].exp_pushes);
      if (vecs[i].exp_pushes > 0) begin
        check({vecs[i].name, "_var"}, pv, vecs[i].exp_var);
        check({vecs[i].name, "_val"}, pval, vecs[i].exp_val);
        check({vecs[i].name, "_type"}, ptype, 1);
      end
      check({vecs[i].name, "_conflict"}, conflict, vecs[i].exp_conf);
      if (vecs[i].exp_conf) begin
        // Requests made while in conflict must never reach the clause DB.
        reads = 0;
        for (int c = 0; c < 6; c++) begin
          @(negedge clock); bcp_en = (c < 2); bcp_clause_idx = 8'd10; #1;
          if (cdb_read) reads++;
        end
        check({vecs[i].name, "_ignored_reads"}, reads, 0);
        check({vecs[i].name, "_ignored_busy"}, bcp_busy, 0);
        check({vecs[i].name, "_held"}, conflict, 1);
        @(negedge clock); reset_bcp = 1'b1;
        @(negedge clock); reset_bcp = 1'b0; #1;
        check({vecs[i].name, "_cleared"}, conflict, 0);
        check({vecs[i].name, "_cleared_busy"}, bcp_busy, 0);
      end
    end

    // Backpressure: full_imply high through the first four IMPLY cycles (10..13).
    load_clause(30, vecs[1]);
    first_push = -1; pushes = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock); bcp_en = (c == 0); bcp_clause_idx = 8'd30; full_imply = (c < 14); #1;
      if (push_imply) begin pushes++; if (first_push < 0) first_push = c; end
      if (c >= 10 && c <= 14) begin
        check($sformatf("bp_var_c%0d", c), var_in_imply, 3);
        check($sformatf("bp_val_c%0d", c), val_in_imply, 0);
      end
    end
    check("bp_first_push", first_push, 14);
    check("bp_pushes", pushes, 1);
    check("bp_done", bcp_busy, 0);

    // Burst of six back-to-back requests into a four-entry FIFO.
    for (int i = 40; i < 46; i++) begin
      clause_mem[i] = {lit(0,0,0), lit(1,0,7), lit(1,0,6)};
    end
    var_una_mem[6] = 1'b1; var_una_mem[7] = 1'b1;
    for (int i = 40; i < 45; i++) exp_addr.push_back(CB'(i));
    reads = 0; idle_reads = -1; busy_gap = 1'b0;
    for (int c = 0; c < 120 && idle_reads < 0; c++) begin
      @(negedge clock); bcp_en = (c < 6); bcp_clause_idx = CB'(40 + c); #1;
      if (cdb_read) begin
        reads++;
        if (exp_addr.size() > 0) check($sformatf("burst_addr_%0d", reads), cdb_addr, exp_addr.pop_front());
      end
      if (!bcp_busy) idle_reads = reads;
    end
    check("burst_reads_at_idle", idle_reads, 5);
    check("burst_overflow", bcp_overflow, 1);
    check("burst_no_conflict", conflict, 0);
    @(negedge clock); reset_bcp = 1'b1;
    @(negedge clock); reset_bcp = 1'b0; #1;
    check("overflow_kept", bcp_overflow, 1);

    // Async reset while a push is held off, with a second request still queued.
    for (int c = 0; c < 12; c++) begin
      @(negedge clock); bcp_en = (c == 0 || c == 3); bcp_clause_idx = 8'd30; full_imply = 1'b1;
    end
    @(negedge clock); full_imply = 1'b0; reset_n = 1'b0; #1;
    check("arst_push", push_imply, 0);
    check("arst_busy", bcp_busy, 0);
    check("arst_overflow", bcp_overflow, 0);
    @(negedge clock); reset_n = 1'b1;
    reads = 0; pushes = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock); #1;
      if (cdb_read) reads++;
      if (push_imply) pushes++;
    end
    check("arst_fifo_empty_reads", reads, 0);
    check("arst_no_push", pushes, 0);
    check("arst_idle", bcp_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
